// File: rtl/ddt_pixel_buffer.sv
// ddt_pixel_buffer
//   Single-clock pixel word buffer between the DDT decoder (writer) and the
//   RGB formatter (reader). A command (Start + Mode/Base_Addr/Len) runs either
//   a write burst with Wr_Valid/Wr_Ready handshake or a read burst that issues
//   one word per cycle and delivers it RD_LAT cycles later.
//
// Ports
//   Sys_Clock, Reset          : clock, synchronous active-high reset
//   Start, Mode, Base_Addr,
//   Len                       : command strobe and arguments (sampled when idle)
//   Wr_Valid, Wr_Data,
//   Wr_Ready, Par_Inj         : write beat handshake, parity-flip test hook
//   Rd_Valid, Rd_Data, Par_Err: read stream and per-word parity error
//   Busy, Done, Cmd_Err       : status; Done/Cmd_Err are one-cycle pulses
//
// Build option
//   DDT_BUF_PARITY_EN : adds an even-parity bit per stored word and drives
//                       Par_Err; without it Par_Inj is ignored and Par_Err=0.
//
// Memory contents are intentionally not cleared by Reset.

module ddt_pixel_buffer #(
    parameter int unsigned DATA_W = 27,
    parameter int unsigned DEPTH  = 21,
    parameter int unsigned RD_LAT = 2,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              Sys_Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W:0]   Len,
    input  logic              Wr_Valid,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic              Wr_Ready,
    input  logic              Par_Inj,
    output logic              Rd_Valid,
    output logic [DATA_W-1:0] Rd_Data,
    output logic              Par_Err,
    output logic              Busy,
    output logic              Done,
    output logic              Cmd_Err
);

`ifdef DDT_BUF_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    // Marks the output stage of the read pipeline.
    localparam logic [RD_LAT-1:0] LastMask = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_busy;
    logic              r_wr_ready;
    logic              r_done;
    logic              r_cmd_err;

    logic [MEM_W-1:0]  r_mem [DEPTH];

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_perr;
    logic [DATA_W-1:0] r_dat [RD_LAT];

    logic              w_wr_fire;
    logic              w_issue;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_base_bad;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;
    logic              w_rd_perr;
    logic              w_drain_empty;

    assign w_wr_fire  = (r_state == StWrite) && Wr_Valid;
    assign w_issue    = (r_state == StRead);
    assign w_ptr_next = (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    // Widened compare so a power-of-two DEPTH cannot overflow the check.
    assign w_base_bad = {1'b0, Base_Addr} >= (ADDR_W + 1)'(DEPTH);
    assign w_rd_word  = r_mem[r_ptr];
    // Nothing new enters during DRAIN, so once only the output stage can hold
    // a word, the last word is on Rd_Data this cycle.
    assign w_drain_empty = ~|(r_vld & ~LastMask);

`ifdef DDT_BUF_PARITY_EN
    assign w_wr_word = {^Wr_Data ^ Par_Inj, Wr_Data};
    assign w_rd_perr = ^w_rd_word;
    assign Par_Err   = r_perr[RD_LAT-1];
`else
    logic w_unused_par;
    assign w_wr_word    = Wr_Data;
    assign w_rd_perr    = 1'b0;
    assign Par_Err      = 1'b0;
    assign w_unused_par = Par_Inj ^ (^r_perr);
`endif

    assign Wr_Ready = r_wr_ready;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Cmd_Err  = r_cmd_err;
    assign Rd_Valid = r_vld[RD_LAT-1];
    assign Rd_Data  = r_dat[RD_LAT-1];

    // Storage: a beat coinciding with Reset is dropped.
    always_ff @(posedge Sys_Clock) begin
        if (!Reset && w_wr_fire) begin
            r_mem[r_ptr] <= w_wr_word;
        end
    end

    // Read pipeline: stage 0 captures the issued word, then shifts toward the
    // output so a word issued in cycle i appears in cycle i+RD_LAT.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            r_vld  <= '0;
            r_perr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vld[i]  <= r_vld[i-1];
                r_perr[i] <= r_perr[i-1];
                r_dat[i]  <= r_dat[i-1];
            end
            r_vld[0]  <= w_issue;
            r_perr[0] <= w_issue & w_rd_perr;
            r_dat[0]  <= w_issue ? w_rd_word[DATA_W-1:0] : '0;
        end
    end

    // Command FSM with registered status outputs.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (Start) begin
                        if (w_base_bad) begin
                            r_cmd_err <= 1'b1;
                        end else if (Len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr  <= Base_Addr;
                            r_cnt  <= Len;
                            r_busy <= 1'b1;
                            if (Mode) begin
                                r_state <= StRead;
                            end else begin
                                r_state    <= StWrite;
                                r_wr_ready <= 1'b1;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (Wr_Valid) begin
                        r_ptr <= w_ptr_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == (ADDR_W + 1)'(1)) begin
                            r_state    <= StIdle;
                            r_busy     <= 1'b0;
                            r_wr_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    r_ptr <= w_ptr_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == (ADDR_W + 1)'(1)) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_drain_empty) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/ddt_pixel_buffer.md
# ddt_pixel_buffer

Parametrised single-clock pixel word buffer for the DDT-to-RGB datapath. It is the successor of the fixed 27-bit × 21-entry memory. It replaces level-decoded EN/WE modes with a command interface: base address plus length, burst write with valid/ready, and burst read with a configurable pipelined read latency. It sits between the DDT decoder, which writes captured pixel words, and the RGB formatter, which reads them back in order.

## Interface
Parameters:
- DATA_W, 27, pixel word width in bits
- DEPTH, 21, number of words; ADDR_W = $clog2(DEPTH)
- RD_LAT, 2, read latency in cycles from issue to Rd_Valid; legal range 1..4

Ports:
- Sys_Clock  in  1  sole clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  command strobe; sampled only when Busy=0
- Mode  in  1  0 = write burst, 1 = read burst; sampled with Start
- Base_Addr  in  ADDR_W  first word address; sampled with Start
- Len  in  ADDR_W+1  number of words; sampled with Start
- Wr_Valid  in  1  write beat offered
- Wr_Data  in  DATA_W  write word
- Wr_Ready  out  1  buffer accepts a beat
- Par_Inj  in  1  invert stored parity on an accepted beat (test hook)
- Rd_Valid  out  1  Rd_Data is valid this cycle
- Rd_Data  out  DATA_W  read word
- Par_Err  out  1  parity mismatch on the current Rd_Valid word
- Busy  out  1  command in progress
- Done  out  1  one-cycle completion pulse
- Cmd_Err  out  1  one-cycle pulse when a command is rejected

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN. Reset value is IDLE.
- IDLE: Start=1 with Base_Addr≥DEPTH → Cmd_Err pulses next cycle and the state stays IDLE.
- IDLE: Start=1 with Len=0 → Done pulses next cycle with no memory access.
- IDLE: otherwise Start=1 → WRITE (Mode=0) or READ (Mode=1). Address pointer is loaded with Base_Addr, remaining count with Len.
- WRITE: Wr_Ready=1. Each cycle with Wr_Valid=1 stores Wr_Data at the pointer, increments the pointer and decrements the count. After the final beat the state goes to IDLE.
- READ: issues one read per cycle, unconditionally (there is no read back-pressure). The pointer increments each cycle. After the last issue the state goes to DRAIN.
- DRAIN: waits until the read pipeline is empty, then goes to IDLE.
- Pointer wrap: the address after DEPTH-1 is 0. Len>DEPTH is legal; later words overwrite, or re-read, earlier addresses.
- Start while Busy=1 is ignored, with no Cmd_Err.
- Memory contents are not cleared by Reset.
- Reset mid-operation: the state returns to IDLE and the read pipeline is flushed, so Rd_Valid=0 and there is no Done. Words already written persist.
- Reset values: Wr_Ready=0, Rd_Valid=0, Rd_Data=0, Par_Err=0, Busy=0, Done=0, Cmd_Err=0.

## Timing
- Start accepted in cycle t → Busy=1 from t+1. In WRITE, Wr_Ready=1 from t+1.
- Write beat accepted in cycle c → the word is readable by any read issued at c+1 or later.
- Read issued in cycle i → Rd_Valid=1 with the word at cycle i+RD_LAT. Len words arrive on consecutive cycles with no gaps.
- Done goes high one cycle after the last accepted write beat, or one cycle after the last Rd_Valid. Busy=0 in that same cycle.
- A new Start is accepted in the Done cycle.
- Back-to-back read commands therefore have a gap of at least 1 cycle between their Rd_Valid streams.

## Configuration
- DDT_BUF_PARITY_EN defined:
  - Memory is DATA_W+1 bits wide; the extra bit holds even parity of Wr_Data, XOR Par_Inj.
  - On read, Par_Err=1 in the same cycle as Rd_Valid when the recomputed parity mismatches.
- DDT_BUF_PARITY_EN undefined:
  - Memory is DATA_W wide.
  - Par_Inj is ignored and Par_Err is constant 0.
- All ports exist in both builds.

## Test plan
- Reset, then write Base=3, Len=4, data 0x1,0x2,0x3,0x4 with Wr_Valid held high → Done 1 cycle after the 4th beat. Then read Base=3, Len=4 → Rd_Valid for 4 consecutive cycles, data 0x1..0x4, first word RD_LAT cycles after the first issue.
- Write Base=19, Len=4 (DEPTH=21), data 0xA..0xD → addresses 19,20,0,1 are written. A read at Base=0, Len=2 returns 0xC, 0xD.
- Start with Base_Addr=21 → Cmd_Err for 1 cycle, Busy stays 0. Start with Len=0 → Done 1 cycle later with no Rd_Valid.
- Write with Wr_Valid toggling 1,0,1,0 for Len=2 → exactly 2 words stored, Done after the 2nd beat. A Start pulsed while Busy=1 is ignored.
- Read Len=5, Reset asserted after the 2nd Rd_Valid → Rd_Valid=0 from the next cycle, no Done. Data read afterwards is unchanged.
- With DDT_BUF_PARITY_EN: write 0x5 with Par_Inj=1, then read it → Par_Err=1 with Rd_Valid. Without the macro, the same stimulus gives Par_Err=0.
